// File: rtl/nibble_serial_cmp.sv
// ----------------------------------------------------------------------------
// nibble_serial_cmp
//
// Sequential magnitude comparator for two WIDTH-bit operands. The operands are
// captured on an accepted start and presented to an external 4-bit comparator
// (cmp4bit) one nibble pair per cycle, most significant nibble first. The scan
// stops at the first nibble pair that differs, or after the last nibble if
// every pair matched. This gives wide compares through a narrow comparator.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   start        compare request; accepted only in IDLE or DONE
//   a, b         operands, captured when start is accepted
//   cmp_a/cmp_b  nibble pair to cmp4bit ([0:3], bit 0 is the MSB)
//   cmp_ahigher  cmp4bit result: A nibble > B nibble
//   cmp_alower   cmp4bit result: A nibble < B nibble
//   cmp_asame    cmp4bit result: A nibble == B nibble
//   busy         high while nibbles are being scanned
//   done         one-cycle pulse when the result is valid
//   ahigher      final result A > B   (registered, held until next start)
//   alower       final result A < B   (registered, held until next start)
//   asame        final result A == B  (registered, held until next start)
//   ncmp         number of nibbles examined in the last compare
// ----------------------------------------------------------------------------
module nibble_serial_cmp #(
   parameter  int WIDTH = 16,             // multiple of 4, at least 4
   localparam int NIB   = WIDTH / 4,
   localparam int CW    = $clog2(NIB) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [0:3]       cmp_a,
   output logic [0:3]       cmp_b,
   input  logic             cmp_ahigher,
   input  logic             cmp_alower,
   input  logic             cmp_asame,
   output logic             busy,
   output logic             done,
   output logic             ahigher,
   output logic             alower,
   output logic             asame,
   output logic [CW-1:0]    ncmp
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb;     // captured operands, shifted left as the scan advances
   logic [CW-1:0]    idx;        // 0-based index of the nibble pair being compared
   logic             accept;
   logic             last;
   logic             nibble_eq;

   // A new compare can be launched from IDLE, or straight out of DONE for
   // back-to-back operation. start is ignored during SCAN.
   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (idx == CW'(NIB - 1));

   // A cycle where the comparator reports neither higher nor lower is taken as
   // equal, whether or not cmp_asame is asserted.
   assign nibble_eq = cmp_asame || !(cmp_ahigher || cmp_alower);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // -------------------------------------------------------------------------
   // Next-state and combinational outputs
   // -------------------------------------------------------------------------
   // NOTE: every signal written here is given a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      cmp_a    = 4'h0;
      cmp_b    = 4'h0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = SCAN;
         end
         SCAN: begin
            busy  = 1'b1;
            cmp_a = sa[WIDTH-1 -: 4];
            cmp_b = sb[WIDTH-1 -: 4];
            if (cmp_ahigher || cmp_alower || last) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = start ? SCAN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Operand shifters, nibble index and registered results
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sa      <= '0;
         sb      <= '0;
         idx     <= '0;
         ahigher <= 1'b0;
         alower  <= 1'b0;
         asame   <= 1'b0;
         ncmp    <= '0;
      end else if (accept) begin
         sa      <= a;
         sb      <= b;
         idx     <= '0;
         ahigher <= 1'b0;
         alower  <= 1'b0;
         asame   <= 1'b0;
         ncmp    <= '0;
      end else if (state == SCAN) begin
         // Priority: higher beats lower; equality only finishes on the last nibble.
         if (cmp_ahigher) begin
            ahigher <= 1'b1;
            ncmp    <= idx + CW'(1);
         end else if (cmp_alower) begin
            alower  <= 1'b1;
            ncmp    <= idx + CW'(1);
         end else if (nibble_eq && last) begin
            asame   <= 1'b1;
            ncmp    <= CW'(NIB);
         end else begin
            sa      <= sa << 4;
            sb      <= sb << 4;
            idx     <= idx + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_cmp.sv
// ----------------------------------------------------------------------------
// tb_nibble_serial_cmp
//
// Bench for nibble_serial_cmp (WIDTH=16). A behavioural cmp4bit stub sits
// between cmp_a/cmp_b and the cmp_* result inputs; it can be switched to
// force all-zero or both-high responses. Expected results come from plain
// integer comparison of the operands and a first-differing-nibble search.
// ----------------------------------------------------------------------------
module tb_nibble_serial_cmp;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;
   localparam int CW    = $clog2(NIB) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic [0:3]       cmp_a, cmp_b;
   logic             cmp_ahigher, cmp_alower, cmp_asame;
   logic             busy, done, ahigher, alower, asame;
   logic [CW-1:0]    ncmp;

   int stub_mode = 0;   // 0: real cmp4bit, 1: all outputs 0, 2: higher and lower both 1
   int n_cmp     = 0;
   int n_err     = 0;

   nibble_serial_cmp #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .cmp_a       (cmp_a),
      .cmp_b       (cmp_b),
      .cmp_ahigher (cmp_ahigher),
      .cmp_alower  (cmp_alower),
      .cmp_asame   (cmp_asame),
      .busy        (busy),
      .done        (done),
      .ahigher     (ahigher),
      .alower      (alower),
      .asame       (asame),
      .ncmp        (ncmp)
   );

   always #5 clk = ~clk;

   // cmp4bit stand-in
   always_comb begin
      cmp_ahigher = 1'b0;
      cmp_alower  = 1'b0;
      cmp_asame   = 1'b0;
      case (stub_mode)
         0: begin
            cmp_ahigher = (cmp_a > cmp_b);
            cmp_alower  = (cmp_a < cmp_b);
            cmp_asame   = (cmp_a == cmp_b);
         end
         2: begin
            cmp_ahigher = 1'b1;
            cmp_alower  = 1'b1;
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int nib_of(input logic [WIDTH-1:0] v, input int i);
      return int'((v >> (4 * (NIB - 1 - i))) & 16'hF);
   endfunction

   // Reference: magnitude from integer compare, k from first differing nibble.
   task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                        output int hi, output int lo, output int eq, output int k);
      hi = (ma > mb) ? 1 : 0;
      lo = (ma < mb) ? 1 : 0;
      eq = (ma == mb) ? 1 : 0;
      k  = NIB;
      for (int i = NIB - 1; i >= 0; i--)
         if (nib_of(ma, i) != nib_of(mb, i)) k = i + 1;
   endtask

   // Launch a compare at the current negedge and follow it until its done
   // cycle (returns positioned at the done negedge). ign_start pulses start
   // during the first two SCAN cycles; those pulses must be ignored.
   task automatic run_cmp(input string tag, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb_v, input bit ign_start);
      int hi, lo, eq, k, cyc;
      if (stub_mode == 0)      model(ta, tb_v, hi, lo, eq, k);
      else if (stub_mode == 1) begin hi = 0; lo = 0; eq = 1; k = NIB; end
      else                     begin hi = 1; lo = 0; eq = 0; k = 1; end
      a = ta; b = tb_v; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      chk({tag, ".clr"}, {ahigher, alower, asame, 29'(ncmp)}, 32'h0);
      cyc = 0;
      while (!done) begin
         cyc++;
         if (cyc > NIB + 1) begin
            chk({tag, ".timeout"}, 32'(cyc), 32'(k));
            break;
         end
         chk({tag, ".busy"}, 32'(busy), 32'd1);
         chk({tag, ".cmp_a"}, 32'(cmp_a), 32'(nib_of(ta, cyc - 1)));
         chk({tag, ".cmp_b"}, 32'(cmp_b), 32'(nib_of(tb_v, cyc - 1)));
         start = ign_start && (cyc <= 2);
         @(negedge clk);
         start = 1'b0;
      end
      chk({tag, ".lat"}, 32'(cyc), 32'(k));
      chk({tag, ".busy_done"}, 32'(busy), 32'd0);
      chk({tag, ".cmp_idle"}, {24'h0, cmp_a, cmp_b}, 32'h0);
      chk({tag, ".res"}, {29'h0, ahigher, alower, asame}, 32'({hi[0], lo[0], eq[0]}));
      chk({tag, ".ncmp"}, 32'(ncmp), 32'(k));
   endtask

   initial begin
      int hi, lo, eq, k, keep;
      logic [WIDTH-1:0] ra, rb, mask;

      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("rst.state", {27'h0, busy, done, ahigher, alower, asame}, 32'h0);
      chk("rst.ncmp", 32'(ncmp), 32'h0);
      chk("rst.cmp", {24'h0, cmp_a, cmp_b}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // 1 + 4: equal operands with ignored starts, then back-to-back compare
      run_cmp("eq", 16'h1234, 16'h1234, 1'b1);
      run_cmp("b2b", 16'hFFFF, 16'h0000, 1'b0);
      @(negedge clk);
      chk("b2b.idle_done", 32'(done), 32'd0);

      // 2: difference in the first nibble
      run_cmp("msb", 16'h8000, 16'h7FFF, 1'b0);
      @(negedge clk);

      // 3: difference in the third nibble, results held while idle
      run_cmp("mid", 16'h12A4, 16'h12B4, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold.done", 32'(done), 32'd0);
         chk("hold.res", {28'h0, busy, ahigher, alower, asame}, 32'h2);
         chk("hold.ncmp", 32'(ncmp), 32'd3);
      end

      // 5: reset in the second SCAN cycle aborts the compare
      a = 16'h1234; b = 16'h1234; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort.state", {27'h0, busy, done, ahigher, alower, asame}, 32'h0);
      chk("abort.ncmp", 32'(ncmp), 32'h0);
      chk("abort.cmp", {24'h0, cmp_a, cmp_b}, 32'h0);
      for (int i = 0; i < NIB + 2; i++) begin
         @(negedge clk);
         chk("abort.nodone", {30'h0, busy, done}, 32'h0);
      end
      run_cmp("after_rst", 16'h5A5A, 16'h5A4A, 1'b0);
      @(negedge clk);

      // 6: stubbed comparator responses
      stub_mode = 1;
      run_cmp("stub_zero", 16'h0001, 16'h0002, 1'b0);
      @(negedge clk);
      stub_mode = 2;
      run_cmp("stub_both", 16'h0001, 16'h0002, 1'b0);
      @(negedge clk);
      stub_mode = 0;

      // Randomized compares with shared high-order prefixes of random length
      for (int n = 0; n < 60; n++) begin
         ra   = 16'($urandom);
         keep = $urandom_range(0, NIB);
         mask = (keep == 0) ? 16'h0 : 16'(16'hFFFF << (4 * (NIB - keep)));
         rb   = (ra & mask) | (16'($urandom) & ~mask);
         model(ra, rb, hi, lo, eq, k);
         run_cmp("rand", ra, rb, 1'($urandom_range(0, 1)));
         // back-to-back on odd iterations, otherwise idle for a few cycles
         if (n % 2 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
